// File: rtl/multi_bus_sync.sv
// multi_bus_sync: retimes NUM_CH independent asynchronous buses into the
// i_clk_b domain. A channel's output only takes a new value after its
// retimed sample has been seen unchanged for STABLE_CNT comparisons.
// Valid/ready handshakes: none. o_update is a one-cycle strobe with no
// backpressure, and o_data_b is valid in every cycle.
module multi_bus_sync #(
  parameter int                   NUM_CH     = 4,
  parameter int                   BUS_WIDTH  = 8,
  parameter int                   NUM_RETIME = 2,
  parameter int                   STABLE_CNT = 1,
  parameter logic [BUS_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                        i_clk_b,
  input  logic                        i_rst_b,
  input  logic [NUM_CH*BUS_WIDTH-1:0] i_data_a,
  input  logic [NUM_CH-1:0]           i_glitch_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] o_data_b,
  output logic [NUM_CH-1:0]           o_update,
  output logic [NUM_CH-1:0]           o_stable,
  output logic [NUM_CH-1:0]           o_glitch
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  // The counter saturates at this value.
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_INC = CW'(1);

  // The update is armed when cnt >= STABLE_CNT-1. That comparison is written
  // as cnt+1 >= STABLE_CNT, one bit wider, so that it never underflows.
  localparam logic [CW:0] CNT_ARM = (CW + 1)'(STABLE_CNT);
  localparam logic [CW:0] ARM_INC = (CW + 1)'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [BUS_WIDTH-1:0] sync_q [NUM_RETIME];
    logic [BUS_WIDTH-1:0] s;
    logic [BUS_WIDTH-1:0] prev_q;
    logic [BUS_WIDTH-1:0] data_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [CW:0]          cnt_plus1;
    logic                 same;
    logic                 armed;
    logic                 load;
    logic                 glitch_set;
    logic                 upd_q;
    logic                 stb_q;
    logic                 glt_q;

    assign s          = sync_q[NUM_RETIME-1];
    assign same       = (s == prev_q);
    assign cnt_plus1  = {1'b0, cnt_q} + ARM_INC;
    assign armed      = (cnt_plus1 >= CNT_ARM);
    assign load       = same && armed && (s != data_q);
    // A change seen while the count is part-way up is a glitch. A change seen
    // after saturation is a legitimate new value, so it is not flagged.
    assign glitch_set = !same && (cnt_q != '0) && (cnt_q != CNT_SAT);

    // Next value of the stability counter: restart on change, otherwise count up to saturation.
    always_comb begin
      cnt_d = cnt_q;
      if (!same) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_INC;
      end
    end

    // Retime chain, sample history, qualification and the registered status flags.
    always_ff @(posedge i_clk_b) begin
      if (i_rst_b) begin
        for (int i = 0; i < NUM_RETIME; i++) begin
          sync_q[i] <= RESET_VAL;
        end
        prev_q <= RESET_VAL;
        data_q <= RESET_VAL;
        cnt_q  <= '0;
        upd_q  <= 1'b0;
        stb_q  <= 1'b0;
        glt_q  <= 1'b0;
      end else begin
        sync_q[0] <= i_data_a[c*BUS_WIDTH +: BUS_WIDTH];
        for (int i = 1; i < NUM_RETIME; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
        prev_q <= s;
        cnt_q  <= cnt_d;
        stb_q  <= (cnt_d == CNT_SAT);
        upd_q  <= load;
        if (load) begin
          data_q <= s;
        end
        // A glitch that sets in the same cycle as a clear wins over the clear.
        if (glitch_set) begin
          glt_q <= 1'b1;
        end else if (i_glitch_clr[c]) begin
          glt_q <= 1'b0;
        end
      end
    end

    assign o_data_b[c*BUS_WIDTH +: BUS_WIDTH] = data_q;
    assign o_update[c] = upd_q;
    assign o_stable[c] = stb_q;
    assign o_glitch[c] = glt_q;
  end

endmodule

// File: tb/tb_multi_bus_sync.sv
// Directed bench for multi_bus_sync. The main instance uses NUM_RETIME=2 and
// STABLE_CNT=3. A second instance with STABLE_CNT=1 covers the two-sample
// agreement filter. Inputs change 1 ns after a rising edge, and outputs are
// sampled at that same point.
module tb_multi_bus_sync;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_a;
  logic [3:0]  clr;
  logic [31:0] data_b;
  logic [3:0]  upd;
  logic [3:0]  stb;
  logic [3:0]  glt;

  logic [31:0] d1_a;
  logic [3:0]  clr1;
  logic [31:0] d1_b;
  logic [3:0]  upd1;
  logic [3:0]  stb1;
  logic [3:0]  glt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_bus_sync #(
    .NUM_CH(4), .BUS_WIDTH(8), .NUM_RETIME(2), .STABLE_CNT(3), .RESET_VAL(8'h00)
  ) dut (
    .i_clk_b(clk), .i_rst_b(rst), .i_data_a(data_a), .i_glitch_clr(clr),
    .o_data_b(data_b), .o_update(upd), .o_stable(stb), .o_glitch(glt)
  );

  multi_bus_sync #(
    .NUM_CH(4), .BUS_WIDTH(8), .NUM_RETIME(2), .STABLE_CNT(1), .RESET_VAL(8'h00)
  ) dut1 (
    .i_clk_b(clk), .i_rst_b(rst), .i_data_a(d1_a), .i_glitch_clr(clr1),
    .o_data_b(d1_b), .o_update(upd1), .o_stable(stb1), .o_glitch(glt1)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (data_b !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", data_b, 32'h0); end
    checks++; if ({upd, stb, glt} !== 12'h000) begin errors++; $display("FAIL reset_flags: got %h expected %h", {upd, stb, glt}, 12'h000); end
    checks++; if (d1_b !== 32'h0) begin errors++; $display("FAIL reset_data1: got %h expected %h", d1_b, 32'h0); end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if ({upd1, upd} !== 8'h00) begin errors++; $display("FAIL reset_nopulse k=%0d: got %h expected %h", k, {upd1, upd}, 8'h00); end
    end
    checks++; if (stb !== 4'hF) begin errors++; $display("FAIL reset_stable: got %h expected %h", stb, 4'hF); end
  endtask

  task automatic test_step_ch0();
    logic [3:0]  exp_upd;
    logic [31:0] exp_d;
    data_a[7:0] = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_upd = (k == 6) ? 4'b0001 : 4'b0000;
      exp_d   = (k >= 6) ? 32'h0000_00A5 : 32'h0;
      checks++; if (upd !== exp_upd) begin errors++; $display("FAIL step_update k=%0d: got %h expected %h", k, upd, exp_upd); end
      checks++; if (data_b !== exp_d) begin errors++; $display("FAIL step_data k=%0d: got %h expected %h", k, data_b, exp_d); end
      if (k == 3) begin
        checks++; if (stb !== 4'b1110) begin errors++; $display("FAIL step_stable_drop: got %h expected %h", stb, 4'b1110); end
      end
      if (k == 6) begin
        checks++; if (stb !== 4'hF) begin errors++; $display("FAIL step_stable_back: got %h expected %h", stb, 4'hF); end
      end
    end
    checks++; if (glt !== 4'h0) begin errors++; $display("FAIL step_no_glitch: got %h expected %h", glt, 4'h0); end
  endtask

  task automatic test_toggle_ch1();
    for (int i = 0; i < 20; i++) begin
      data_a[15:8] = (i % 2 == 0) ? 8'h11 : 8'h22;
      tick();
      checks++; if (upd !== 4'h0) begin errors++; $display("FAIL toggle_update i=%0d: got %h expected %h", i, upd, 4'h0); end
      checks++; if (data_b[15:8] !== 8'h00) begin errors++; $display("FAIL toggle_data i=%0d: got %h expected %h", i, data_b[15:8], 8'h00); end
      checks++; if (glt[1] !== 1'b0) begin errors++; $display("FAIL toggle_glitch i=%0d: got %b expected %b", i, glt[1], 1'b0); end
    end
    // Hold 0x11 for two samples so the count reaches 1, then break it for one cycle.
    data_a[15:8] = 8'h11;
    tick();
    tick();
    data_a[15:8] = 8'h22;
    tick();
    data_a[15:8] = 8'h11;
    tick();
    checks++; if (glt[1] !== 1'b0) begin errors++; $display("FAIL glitch_not_yet: got %b expected %b", glt[1], 1'b0); end
    tick();
    checks++; if (glt[1] !== 1'b1) begin errors++; $display("FAIL glitch_set: got %b expected %b", glt[1], 1'b1); end
    checks++; if (data_b[15:8] !== 8'h00) begin errors++; $display("FAIL glitch_data_held: got %h expected %h", data_b[15:8], 8'h00); end
    repeat (6) tick();
    checks++; if (data_b[15:8] !== 8'h11) begin errors++; $display("FAIL ch1_settle: got %h expected %h", data_b[15:8], 8'h11); end
    checks++; if (glt[1] !== 1'b1) begin errors++; $display("FAIL glitch_sticky: got %b expected %b", glt[1], 1'b1); end
    clr = 4'b0010;
    tick();
    clr = 4'b0000;
    checks++; if (glt !== 4'h0) begin errors++; $display("FAIL glitch_clear1: got %h expected %h", glt, 4'h0); end
  endtask

  task automatic test_glitch_clr_ch2();
    data_a[23:16] = 8'h33; tick();
    data_a[23:16] = 8'h33; tick();
    data_a[23:16] = 8'h44; tick();
    data_a[23:16] = 8'h44; tick();
    data_a[23:16] = 8'h33; tick();
    checks++; if (glt[2] !== 1'b1) begin errors++; $display("FAIL clr_first_glitch: got %b expected %b", glt[2], 1'b1); end
    tick();
    checks++; if (glt[2] !== 1'b1) begin errors++; $display("FAIL clr_sticky: got %b expected %b", glt[2], 1'b1); end
    clr = 4'b0100;
    tick();
    checks++; if (glt[2] !== 1'b1) begin errors++; $display("FAIL clr_set_priority: got %b expected %b", glt[2], 1'b1); end
    tick();
    checks++; if (glt[2] !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b expected %b", glt[2], 1'b0); end
    clr = 4'b0000;
    repeat (6) tick();
    checks++; if (data_b[23:16] !== 8'h33) begin errors++; $display("FAIL ch2_settle: got %h expected %h", data_b[23:16], 8'h33); end
  endtask

  task automatic test_reset_mid_ch3();
    logic [3:0]  exp_upd;
    logic [31:0] exp_d;
    data_a[31:24] = 8'h7E;
    tick();
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (data_b !== 32'h0) begin errors++; $display("FAIL rstmid_data k=%0d: got %h expected %h", k, data_b, 32'h0); end
      checks++; if ({upd, stb, glt} !== 12'h000) begin errors++; $display("FAIL rstmid_flags k=%0d: got %h expected %h", k, {upd, stb, glt}, 12'h000); end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_upd = (k == 6) ? 4'hF : 4'h0;
      exp_d   = (k >= 6) ? 32'h7E33_11A5 : 32'h0;
      checks++; if (upd !== exp_upd) begin errors++; $display("FAIL rstrel_update k=%0d: got %h expected %h", k, upd, exp_upd); end
      checks++; if (data_b !== exp_d) begin errors++; $display("FAIL rstrel_data k=%0d: got %h expected %h", k, data_b, exp_d); end
    end
    clr = 4'hF;
    tick();
    clr = 4'h0;
    checks++; if (glt !== 4'h0) begin errors++; $display("FAIL rstrel_clear: got %h expected %h", glt, 4'h0); end
  endtask

  task automatic test_all_channels();
    logic [3:0]  exp_upd;
    logic [3:0]  exp_stb;
    logic [31:0] exp_d;
    data_a = 32'h91A2_B3C4;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_upd = (k == 6) ? 4'hF : 4'h0;
      exp_stb = (k >= 3 && k < 6) ? 4'h0 : 4'hF;
      exp_d   = (k >= 6) ? 32'h91A2_B3C4 : 32'h7E33_11A5;
      checks++; if (upd !== exp_upd) begin errors++; $display("FAIL all_update k=%0d: got %h expected %h", k, upd, exp_upd); end
      checks++; if (stb !== exp_stb) begin errors++; $display("FAIL all_stable k=%0d: got %h expected %h", k, stb, exp_stb); end
      checks++; if (data_b !== exp_d) begin errors++; $display("FAIL all_data k=%0d: got %h expected %h", k, data_b, exp_d); end
    end
    checks++; if (glt !== 4'h0) begin errors++; $display("FAIL all_no_glitch: got %h expected %h", glt, 4'h0); end
  endtask

  task automatic test_stable1_filter();
    logic [3:0]  exp_upd;
    logic [31:0] exp_d;
    d1_a[7:0] = 8'h5A;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_upd = (k == 4) ? 4'b0001 : 4'b0000;
      exp_d   = (k >= 4) ? 32'h0000_005A : 32'h0;
      checks++; if (upd1 !== exp_upd) begin errors++; $display("FAIL s1_update k=%0d: got %h expected %h", k, upd1, exp_upd); end
      checks++; if (d1_b !== exp_d) begin errors++; $display("FAIL s1_data k=%0d: got %h expected %h", k, d1_b, exp_d); end
    end
    for (int i = 0; i < 12; i++) begin
      d1_a[15:8] = (i % 2 == 0) ? 8'h3C : 8'hC3;
      tick();
      checks++; if (upd1 !== 4'h0) begin errors++; $display("FAIL s1_toggle_update i=%0d: got %h expected %h", i, upd1, 4'h0); end
      checks++; if (d1_b[15:8] !== 8'h00) begin errors++; $display("FAIL s1_toggle_data i=%0d: got %h expected %h", i, d1_b[15:8], 8'h00); end
    end
    repeat (6) tick();
    checks++; if (d1_b[15:8] !== 8'hC3) begin errors++; $display("FAIL s1_hold_settle: got %h expected %h", d1_b[15:8], 8'hC3); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst    = 1'b1;
    data_a = 32'h0;
    clr    = 4'h0;
    d1_a   = 32'h0;
    clr1   = 4'h0;
    test_reset();
    test_step_ch0();
    repeat (2) tick();
    test_toggle_ch1();
    test_glitch_clr_ch2();
    test_reset_mid_ch3();
    test_all_channels();
    test_stable1_filter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
